// File: rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer_pkg.sv
// rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer_pkg.sv - shared OCI trace DCT constants and state type
package niosii_system_nios2_qsys_0_nios2_oci_dct_packer_pkg;
  localparam int DCT_CODE_W = 2;
  localparam int DCT_SLOTS  = 15;
  localparam int DCT_BUF_W  = DCT_CODE_W * DCT_SLOTS;
  localparam int DCT_CNT_W  = 4;

  typedef enum logic {FILL, HOLD} dct_state_e;
endpackage

// File: rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if.sv
// rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if.sv - trace code input, frame output and monitor bundle
interface niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if;
  import niosii_system_nios2_qsys_0_nios2_oci_dct_packer_pkg::*;

  logic                  code_valid;
  logic [DCT_CODE_W-1:0] code;
  logic                  flush;
  logic                  out_ready;
  logic                  out_valid;
  logic [DCT_BUF_W-1:0]  out_buffer;
  logic [DCT_CNT_W-1:0]  out_count;
  logic [DCT_BUF_W-1:0]  dct_buffer;
  logic [DCT_CNT_W-1:0]  dct_count;
  logic                  overflow;
  logic                  overflow_clr;

  modport master (
    output code_valid, code, flush, out_ready, overflow_clr,
    input  out_valid, out_buffer, out_count, dct_buffer, dct_count, overflow
  );

  modport slave (
    input  code_valid, code, flush, out_ready, overflow_clr,
    output out_valid, out_buffer, out_count, dct_buffer, dct_count, overflow
  );
endinterface

// File: rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_outreg.sv
// rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_outreg.sv - one-entry valid/ready register for closed frames
module niosii_system_nios2_qsys_0_nios2_oci_dct_outreg
  import niosii_system_nios2_qsys_0_nios2_oci_dct_packer_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buffer,
  input  logic [DCT_CNT_W-1:0] load_count,
  input  logic                 out_ready,
  output logic                 can_load,
  output logic                 out_valid,
  output logic [DCT_BUF_W-1:0] out_buffer,
  output logic [DCT_CNT_W-1:0] out_count
);
  // can_load only steers the packer; out_valid itself is purely registered
  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_buffer <= '0;
      out_count  <= '0;
    end else if (load) begin
      out_valid  <= 1'b1;
      out_buffer <= load_buffer;
      out_count  <= load_count;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end
endmodule

// File: rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv
// rtl/niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv - packs 2-bit trace codes into 15-slot frames
module niosii_system_nios2_qsys_0_nios2_oci_dct_packer
  import niosii_system_nios2_qsys_0_nios2_oci_dct_packer_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if.slave bus
);
  dct_state_e           state;
  logic [DCT_BUF_W-1:0] acc;
  logic [DCT_CNT_W-1:0] cnt;
  logic [DCT_BUF_W-1:0] frame;
  logic [DCT_CNT_W-1:0] frame_cnt;
  logic [DCT_BUF_W-1:0] load_buffer;
  logic [DCT_CNT_W-1:0] load_count;
  logic                 close;
  logic                 can_load;
  logic                 load;
  logic                 drop;
  logic                 ovf;

  // frame/frame_cnt: the accumulator with this cycle's code already included
  always_comb begin
    frame     = acc;
    frame_cnt = cnt;
    if (bus.code_valid) begin
      for (int i = 0; i < DCT_SLOTS; i++) begin
        if (cnt == DCT_CNT_W'(i)) frame[i*DCT_CODE_W +: DCT_CODE_W] = bus.code;
      end
      frame_cnt = cnt + DCT_CNT_W'(1);
    end
  end

  assign close = (state == FILL) &&
                 ((bus.code_valid && cnt == DCT_CNT_W'(DCT_SLOTS - 1)) ||
                  (bus.flush && frame_cnt != '0));
  assign load        = can_load && (close || state == HOLD);
  assign load_buffer = (state == HOLD) ? acc : frame;
  assign load_count  = (state == HOLD) ? cnt : frame_cnt;
  assign drop        = bus.code_valid && (state == HOLD);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FILL;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (close && can_load) begin
            acc <= '0;
            cnt <= '0;
          end else begin
            // a closed frame that cannot be handed off parks in the accumulator
            acc <= frame;
            cnt <= frame_cnt;
            if (close) state <= HOLD;
          end
        end
        HOLD: begin
          if (can_load) begin
            acc   <= '0;
            cnt   <= '0;
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
      if (drop) ovf <= 1'b1;
      else if (bus.overflow_clr) ovf <= 1'b0;
    end
  end

  assign bus.dct_buffer = acc;
  assign bus.dct_count  = cnt;
  assign bus.overflow   = ovf;

  niosii_system_nios2_qsys_0_nios2_oci_dct_outreg u_outreg (
    .clk         (clk),
    .reset_n     (reset_n),
    .load        (load),
    .load_buffer (load_buffer),
    .load_count  (load_count),
    .out_ready   (bus.out_ready),
    .can_load    (can_load),
    .out_valid   (bus.out_valid),
    .out_buffer  (bus.out_buffer),
    .out_count   (bus.out_count)
  );
endmodule

// File: tb/tb_niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv
// tb/tb_niosii_system_nios2_qsys_0_nios2_oci_dct_packer.sv - directed self-checking bench for the DCT packer
module tb_niosii_system_nios2_qsys_0_nios2_oci_dct_packer;
  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  niosii_system_nios2_qsys_0_nios2_oci_dct_packer_if bus_if ();

  niosii_system_nios2_qsys_0_nios2_oci_dct_packer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drive one cycle of inputs, then leave the single-cycle strobes low
  task automatic step(input logic v, input logic [1:0] c, input logic f, input logic clr);
    bus_if.code_valid   = v;
    bus_if.code         = c;
    bus_if.flush        = f;
    bus_if.overflow_clr = clr;
    tick();
    bus_if.code_valid   = 1'b0;
    bus_if.code         = 2'b00;
    bus_if.flush        = 1'b0;
    bus_if.overflow_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus_if.code_valid = 0; bus_if.code = 0; bus_if.flush = 0;
    bus_if.out_ready = 1; bus_if.overflow_clr = 0;
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
    tick();
    n_cmp++;
    if ({bus_if.out_valid, bus_if.out_buffer, bus_if.out_count, bus_if.dct_buffer,
         bus_if.dct_count, bus_if.overflow} !== 70'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got ov=%b ob=%h oc=%0d db=%h dc=%0d of=%b required all 0",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count, bus_if.dct_buffer,
               bus_if.dct_count, bus_if.overflow);
    end
  endtask

  task automatic test_full_frame();
    bus_if.out_ready = 1;
    for (int i = 0; i < 14; i++) step(1, 2'b11, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b0 || bus_if.dct_count !== 4'd14) begin
      n_bad++;
      $display("FAIL full_pre: out_valid=%b dct_count=%0d required 0/14", bus_if.out_valid, bus_if.dct_count);
    end
    step(1, 2'b11, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_buffer !== 30'h3FFFFFFF || bus_if.out_count !== 4'd15) begin
      n_bad++;
      $display("FAIL full_frame: valid=%b buf=%h cnt=%0d required 1/3fffffff/15",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count);
    end
    n_cmp++;
    if (bus_if.dct_count !== 4'd0 || bus_if.dct_buffer !== 30'h0) begin
      n_bad++;
      $display("FAIL full_dct_clear: dct_count=%0d dct_buffer=%h required 0/0", bus_if.dct_count, bus_if.dct_buffer);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL full_drain: out_valid=%b required 0", bus_if.out_valid);
    end
  endtask

  task automatic test_flush();
    bus_if.out_ready = 1;
    step(1, 2'b01, 0, 0);
    step(1, 2'b10, 0, 0);
    step(1, 2'b11, 0, 0);
    n_cmp++;
    if (bus_if.dct_buffer !== 30'h39 || bus_if.dct_count !== 4'd3 || bus_if.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_partial: dct_buffer=%h dct_count=%0d out_valid=%b required 39/3/0",
               bus_if.dct_buffer, bus_if.dct_count, bus_if.out_valid);
    end
    step(0, 0, 1, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_buffer !== 30'h39 || bus_if.out_count !== 4'd3) begin
      n_bad++;
      $display("FAIL flush_frame: valid=%b buf=%h cnt=%0d required 1/39/3",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count);
    end
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b0 || bus_if.dct_count !== 4'd0) begin
      n_bad++;
      $display("FAIL flush_empty: out_valid=%b dct_count=%0d required 0/0", bus_if.out_valid, bus_if.dct_count);
    end
  endtask

  task automatic test_flush_at_14();
    bus_if.out_ready = 1;
    for (int i = 0; i < 14; i++) step(1, 2'b10, 0, 0);
    step(1, 2'b01, 1, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_buffer !== 30'h1AAAAAAA || bus_if.out_count !== 4'd15) begin
      n_bad++;
      $display("FAIL flush14_frame: valid=%b buf=%h cnt=%0d required 1/1aaaaaaa/15",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b0 || bus_if.dct_count !== 4'd0) begin
      n_bad++;
      $display("FAIL flush14_single: out_valid=%b dct_count=%0d required 0/0", bus_if.out_valid, bus_if.dct_count);
    end
  endtask

  task automatic test_back_to_back();
    bus_if.out_ready = 0;
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 2'b10, 0, 0);
    n_cmp++;
    if (bus_if.dct_buffer !== 30'h2AAAAAAA || bus_if.dct_count !== 4'd15 || bus_if.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_entry: dct_buffer=%h dct_count=%0d overflow=%b required 2aaaaaaa/15/0",
               bus_if.dct_buffer, bus_if.dct_count, bus_if.overflow);
    end
    step(1, 2'b11, 0, 0);
    n_cmp++;
    if (bus_if.overflow !== 1'b1 || bus_if.dct_buffer !== 30'h2AAAAAAA) begin
      n_bad++;
      $display("FAIL hold_drop: overflow=%b dct_buffer=%h required 1/2aaaaaaa", bus_if.overflow, bus_if.dct_buffer);
    end
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_buffer !== 30'h15555555 || bus_if.out_count !== 4'd15) begin
      n_bad++;
      $display("FAIL hold_stable1: valid=%b buf=%h cnt=%0d required 1/15555555/15",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count);
    end
    bus_if.out_ready = 1;
    step(0, 0, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_buffer !== 30'h2AAAAAAA || bus_if.out_count !== 4'd15 ||
        bus_if.dct_count !== 4'd0) begin
      n_bad++;
      $display("FAIL hold_frame2: valid=%b buf=%h cnt=%0d dct_count=%0d required 1/2aaaaaaa/15/0",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count, bus_if.dct_count);
    end
    step(0, 0, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_drained: out_valid=%b required 0", bus_if.out_valid);
    end
  endtask

  task automatic test_overflow_clr();
    step(0, 0, 0, 1);
    n_cmp++;
    if (bus_if.overflow !== 1'b0) begin
      n_bad++;
      $display("FAIL ovf_clear: overflow=%b required 0", bus_if.overflow);
    end
    bus_if.out_ready = 0;
    for (int i = 0; i < 30; i++) step(1, 2'b11, 0, 0);
    step(1, 2'b01, 0, 1);
    n_cmp++;
    if (bus_if.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_set_wins: overflow=%b required 1", bus_if.overflow);
    end
    bus_if.out_ready = 1;
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b0 || bus_if.overflow !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_sticky: out_valid=%b overflow=%b required 0/1", bus_if.out_valid, bus_if.overflow);
    end
  endtask

  task automatic test_async_reset();
    bus_if.out_ready = 0;
    for (int i = 0; i < 15; i++) step(1, 2'b01, 0, 0);
    for (int i = 0; i < 7; i++) step(1, 2'b10, 0, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.dct_count !== 4'd7) begin
      n_bad++;
      $display("FAIL rst_setup: out_valid=%b dct_count=%0d required 1/7", bus_if.out_valid, bus_if.dct_count);
    end
    #2 reset_n = 0;
    #1;
    n_cmp++;
    if ({bus_if.out_valid, bus_if.out_buffer, bus_if.out_count, bus_if.dct_buffer,
         bus_if.dct_count, bus_if.overflow} !== 70'd0) begin
      n_bad++;
      $display("FAIL rst_async: got ov=%b ob=%h oc=%0d db=%h dc=%0d of=%b required all 0",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count, bus_if.dct_buffer,
               bus_if.dct_count, bus_if.overflow);
    end
    tick();
    #2 reset_n = 1;
    bus_if.out_ready = 1;
    tick();
    step(1, 2'b11, 1, 0);
    n_cmp++;
    if (bus_if.out_valid !== 1'b1 || bus_if.out_buffer !== 30'h3 || bus_if.out_count !== 4'd1) begin
      n_bad++;
      $display("FAIL rst_slot0: valid=%b buf=%h cnt=%0d required 1/3/1",
               bus_if.out_valid, bus_if.out_buffer, bus_if.out_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_full_frame();
    test_flush();
    test_flush_at_14();
    test_back_to_back();
    test_overflow_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
